// File: rtl/msp430_ram_arb.sv
// msp430_ram_arb: arbitrates one single-port SRAM (low-active cen/wen, 1-cycle
// registered read) between port 0 (CPU) and port 1 (DMA/debug).
// Optional build macro MSP430_RAM_ARB_RR_EN: when defined, conflicts are resolved
// round-robin (STARVE ignored); when undefined, port 0 has fixed priority and a
// wait counter forces port 1 through after STARVE consecutive denials.
//
// Handshake: a port raises p*_req and holds it (with addr/din/wen stable) until it
// sees p*_gnt in the same cycle; the access completes in that granted cycle.
// Reads return one cycle later as p*_rvalid with p*_dout; writes never return.
module msp430_ram_arb #(
  parameter int AW       = 6,
  parameter int DW       = 16,
  parameter int MEM_SIZE = 256,
  parameter int STARVE   = 4
) (
  input  logic          ram_clk,
  input  logic          ram_rst,
  input  logic          p0_req,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_din,
  input  logic [1:0]    p0_wen,
  output logic          p0_gnt,
  output logic [DW-1:0] p0_dout,
  output logic          p0_rvalid,
  input  logic          p1_req,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_din,
  input  logic [1:0]    p1_wen,
  output logic          p1_gnt,
  output logic [DW-1:0] p1_dout,
  output logic          p1_rvalid,
  output logic          acc_err,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_cen,
  output logic [1:0]    ram_wen,
  input  logic [DW-1:0] ram_dout
);

  localparam int        WORDS      = MEM_SIZE / 2;
  localparam logic [3:0] STARVE_CNT = 4'(STARVE);

  // Which port (if any) is owed read data next cycle.
  typedef enum logic [1:0] {RD_NONE, RD_P0, RD_P1} rd_owner_t;

  rd_owner_t     rd_owner, rd_owner_nxt;
  logic [3:0]    wait_cnt;
  logic          rd_oor;
  logic          acc_err_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] din_q;
  logic [DW-1:0] p0_dout_q, p1_dout_q;

  logic          gnt0, gnt1, any_gnt, in_range, is_read;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_din;
  logic [1:0]    win_wen;
  logic [DW-1:0] rd_data;

`ifdef MSP430_RAM_ARB_RR_EN
  // 0 = port 0 was granted last, 1 = port 1 was granted last.
  logic last_gnt;
`endif

  // Pick the winner for this cycle; no grants while reset is asserted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!ram_rst) begin
`ifdef MSP430_RAM_ARB_RR_EN
      if (p0_req && p1_req) begin
        if (last_gnt) gnt0 = 1'b1;
        else          gnt1 = 1'b1;
      end else begin
        gnt0 = p0_req;
        gnt1 = p1_req;
      end
`else
      if (p1_req && (!p0_req || wait_cnt == STARVE_CNT)) gnt1 = 1'b1;
      else                                                gnt0 = p0_req;
`endif
    end
  end

  // Mux the winner onto the RAM port and work out the read-return owner.
  always_comb begin
    any_gnt      = gnt0 | gnt1;
    win_addr     = gnt1 ? p1_addr : p0_addr;
    win_din      = gnt1 ? p1_din  : p0_din;
    win_wen      = gnt1 ? p1_wen  : p0_wen;
    in_range     = 32'(win_addr) < 32'(WORDS);
    is_read      = any_gnt && (win_wen == 2'b11);
    rd_owner_nxt = RD_NONE;
    if (is_read) rd_owner_nxt = gnt1 ? RD_P1 : RD_P0;
  end

  // Output drive; address/data hold their last granted value while idle.
  always_comb begin
    p0_gnt    = gnt0;
    p1_gnt    = gnt1;
    ram_cen   = !(any_gnt && in_range);
    ram_wen   = any_gnt ? win_wen : 2'b11;
    ram_addr  = ram_rst ? '0 : (any_gnt ? win_addr : addr_q);
    ram_din   = ram_rst ? '0 : (any_gnt ? win_din  : din_q);
    rd_data   = rd_oor ? '0 : ram_dout;
    p0_rvalid = !ram_rst && (rd_owner == RD_P0);
    p1_rvalid = !ram_rst && (rd_owner == RD_P1);
    p0_dout   = ram_rst ? '0 : (p0_rvalid ? rd_data : p0_dout_q);
    p1_dout   = ram_rst ? '0 : (p1_rvalid ? rd_data : p1_dout_q);
    acc_err   = !ram_rst && acc_err_q;
  end

  // Read-owner state register plus out-of-range tracking.
  always_ff @(posedge ram_clk) begin
    if (ram_rst) begin
      rd_owner  <= RD_NONE;
      rd_oor    <= 1'b0;
      acc_err_q <= 1'b0;
    end else begin
      rd_owner  <= rd_owner_nxt;
      rd_oor    <= is_read && !in_range;
      acc_err_q <= any_gnt && !in_range;
    end
  end

  // Port-1 starvation counter, saturating at STARVE.
  always_ff @(posedge ram_clk) begin
    if (ram_rst) begin
      wait_cnt <= 4'd0;
    end else if (!p1_req || gnt1) begin
      wait_cnt <= 4'd0;
    end else if (wait_cnt != STARVE_CNT) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // Hold last RAM address/data and each port's last read data.
  always_ff @(posedge ram_clk) begin
    if (ram_rst) begin
      addr_q    <= '0;
      din_q     <= '0;
      p0_dout_q <= '0;
      p1_dout_q <= '0;
    end else begin
      if (any_gnt) begin
        addr_q <= win_addr;
        din_q  <= win_din;
      end
      if (p0_rvalid) p0_dout_q <= rd_data;
      if (p1_rvalid) p1_dout_q <= rd_data;
    end
  end

`ifdef MSP430_RAM_ARB_RR_EN
  // Remember who won last so the other port wins the next conflict.
  always_ff @(posedge ram_clk) begin
    if (ram_rst)      last_gnt <= 1'b1;
    else if (any_gnt) last_gnt <= gnt1;
  end
`endif

endmodule
